// File: rtl/tof_pkg.sv
// tof_pkg: shared types and constants for the TOF shot sequencer
package tof_pkg;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_START = IDX_W'(1);
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_WINDOW,
    S_LOAD,
    S_FEED,
    S_WAIT_RES,
    S_DONE
  } state_t;
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [15:0]      code;
    logic [13:0]      coarse;
  } hit_t;
endpackage

// File: rtl/tof_hit_fifo.sv
// tof_hit_fifo: synchronous hit buffer, head valid whenever not empty
module tof_hit_fifo import tof_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  hit_t din,
  output logic full,
  output logic empty,
  output hit_t head
);
  localparam int AW = $clog2(DEPTH);
  hit_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] n;
  logic wr, rd;
  assign full = n == (AW + 1)'(DEPTH);
  assign empty = n == '0;
  assign head = mem[rp];
  assign wr = push && !full;
  assign rd = pop && !empty;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      n <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      n <= n + (AW + 1)'(wr) - (AW + 1)'(rd);
    end
endmodule

// File: rtl/tof_seq_ctrl.sv
// tof_seq_ctrl: captures one shot of start/stop hits, then replays them into the TOF calculator
module tof_seq_ctrl import tof_pkg::*; #(
  parameter int MAX_STOPS   = 5,
  parameter int FIFO_DEPTH  = 8,
  parameter int RES_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [15:0]      win_len,
  input  logic             hit_valid,
  input  logic [15:0]      hit_code,
  input  logic [13:0]      hit_coarse,
  output logic [15:0]      decode_out,
  output logic [13:0]      counter_out,
  output logic             cal_en,
  output logic [IDX_W-1:0] cnt,
  output logic [IDX_W-1:0] num_cnt,
  output logic             tri_en,
  input  logic             cal_stop,
  input  logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             timeout_err
);
  localparam int TW = $clog2(RES_TIMEOUT + 1);
  state_t st;
  logic [15:0] win_q, wcnt;
  logic [IDX_W-1:0] stop_cnt;
  logic [TW-1:0] tcnt;
  logic stop_seen, push, pop, full, empty, stop_ok, res_go, feed_go;
  hit_t din, head, cur;
  always_comb begin
    stop_ok = stop_cnt < IDX_W'(MAX_STOPS);
    din = {st == S_WAIT_START ? IDX_START : stop_cnt + IDX_W'(2), hit_code, hit_coarse};
    push = hit_valid && !full && (st == S_WAIT_START || (st == S_WINDOW && stop_ok));
    pop = st == S_FEED && stop_seen;
    res_go = st == S_WAIT_RES && (out_valid || tcnt == TW'(RES_TIMEOUT - 1));
    feed_go = st == S_LOAD || (res_go && !empty);
  end
  tof_hit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .full(full), .empty(empty), .head(head)
  );
  assign busy = st != S_IDLE && st != S_DONE;
  assign done = st == S_DONE;
  assign tri_en = st == S_LOAD;
  assign cal_en = st == S_FEED;
  assign num_cnt = stop_cnt;
  assign decode_out = cur.code;
  assign counter_out = cur.coarse;
  assign cnt = cur.idx;
  always_ff @(posedge clk)
    if (rst) begin
      st <= S_IDLE;
      win_q <= '0;
      wcnt <= '0;
      stop_cnt <= '0;
      stop_seen <= 1'b0;
      tcnt <= '0;
      overflow <= 1'b0;
      timeout_err <= 1'b0;
      cur <= '0;
    end else begin
      case (st)
        S_IDLE:
          if (trig) begin
            st <= S_WAIT_START;
            win_q <= win_len;
            wcnt <= win_len;
            stop_cnt <= '0;
            overflow <= 1'b0;
            timeout_err <= 1'b0;
          end
        S_WAIT_START:
          if (hit_valid) begin
            st <= S_WINDOW;
            wcnt <= win_q;
          end else if (wcnt < 16'd2) st <= S_DONE;
          else wcnt <= wcnt - 16'd1;
        S_WINDOW: begin
          if (hit_valid && stop_ok) stop_cnt <= stop_cnt + 1'b1;
          if (hit_valid && !stop_ok) overflow <= 1'b1;
          if (wcnt == '0) st <= S_LOAD;
          else wcnt <= wcnt - 16'd1;
        end
        S_LOAD: st <= S_FEED;
        // cal_en stays high for one cycle after cal_stop so the calculator sees its last enable
        S_FEED:
          if (stop_seen) begin
            st <= S_WAIT_RES;
            stop_seen <= 1'b0;
            tcnt <= '0;
          end else if (cal_stop) stop_seen <= 1'b1;
        S_WAIT_RES: begin
          tcnt <= tcnt + 1'b1;
          if (res_go) begin
            st <= empty ? S_DONE : S_FEED;
            if (!out_valid) timeout_err <= 1'b1;
          end
        end
        S_DONE: st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
      if (feed_go) cur <= head;
    end
endmodule

// File: tb/tb_tof_seq_ctrl.sv
// tb_tof_seq_ctrl: directed and random shots checked against a shot-level reference model
module tb_tof_seq_ctrl;
  localparam int MAX_STOPS = 5;
  logic clk = 1'b0;
  logic rst = 1'b1, trig = 1'b0, hit_valid = 1'b0, cal_stop = 1'b0, out_valid = 1'b0;
  logic [15:0] win_len = '0, hit_code = '0, decode_out;
  logic [13:0] hit_coarse = '0, counter_out;
  logic [2:0] cnt, num_cnt;
  logic cal_en, tri_en, busy, done, overflow, timeout_err;
  int checks = 0, failures = 0, hold_idx = 0;
  int en_n = 0, pend = -1;
  logic prev_en = 1'b0;

  always #5 clk = ~clk;

  tof_seq_ctrl #(.MAX_STOPS(MAX_STOPS), .FIFO_DEPTH(8), .RES_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .trig(trig), .win_len(win_len), .hit_valid(hit_valid),
    .hit_code(hit_code), .hit_coarse(hit_coarse), .decode_out(decode_out),
    .counter_out(counter_out), .cal_en(cal_en), .cnt(cnt), .num_cnt(num_cnt),
    .tri_en(tri_en), .cal_stop(cal_stop), .out_valid(out_valid), .busy(busy),
    .done(done), .overflow(overflow), .timeout_err(timeout_err)
  );

  // calculator: cal_stop in 4th enable cycle, result 0-4 cycles after enable drops unless withheld
  always @(posedge clk) begin
    #1;
    out_valid = 1'b0;
    en_n = cal_en ? en_n + 1 : 0;
    cal_stop = en_n == 4;
    if (!cal_en && prev_en) pend = (int'(cnt) == hold_idx) ? -1 : int'($urandom_range(0, 4));
    if (pend == 0) out_valid = 1'b1;
    if (pend >= 0) pend--;
    prev_en = cal_en;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    trig = 1'b0;
    hit_valid = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic run_shot(input int win, input int times[$], input int hold,
                          input bit trig_feed, input bit rst_feed);
    logic [15:0] codes[$];
    logic [13:0] crs[$];
    logic [32:0] exp_q[$], got_q[$], cur;
    logic [2:0] tri_num;
    int s, ws_end, nstop, k, tri_n, tri_c, done_n, done_c, first_en, fall_c, unstable;
    bit ov_exp, to_exp, hold_on, pe, fin;
    foreach (times[i]) begin
      codes.push_back(16'(16'hFFFF >> $urandom_range(0, 16)));
      crs.push_back(14'($urandom));
    end
    ws_end = win > 0 ? win : 1;
    s = -1;
    nstop = 0;
    ov_exp = 0;
    foreach (times[i]) begin
      if (s < 0) begin
        if (times[i] >= 1 && times[i] <= ws_end) begin
          s = times[i];
          exp_q.push_back({3'd1, codes[i], crs[i]});
        end
      end else if (times[i] <= s + 1 + win) begin
        if (nstop < MAX_STOPS) begin
          nstop++;
          exp_q.push_back({3'(nstop + 1), codes[i], crs[i]});
        end else ov_exp = 1;
      end
    end
    to_exp = hold >= 1 && hold <= exp_q.size();
    hold_idx = hold;
    tri_n = 0; tri_c = -1; tri_num = '0; done_n = 0; done_c = -1; first_en = -1;
    fall_c = -1; unstable = 0; hold_on = 0; pe = 0; fin = 0; k = 0; cur = '0;
    win_len = 16'(win);
    while (!fin) begin
      trig = k == 0 || (trig_feed && first_en >= 0 && k == first_en + 2);
      rst = rst_feed && first_en >= 0 && k == first_en + 2;
      hit_valid = 1'b0;
      foreach (times[i]) if (times[i] == k) begin
        hit_valid = 1'b1;
        hit_code = codes[i];
        hit_coarse = crs[i];
      end
      @(posedge clk);
      #2;
      k++;
      if (k == 1) chk("trig_clears", {busy, overflow, timeout_err, num_cnt}, {1'b1, 1'b0, 1'b0, 3'd0});
      if (rst_feed && first_en >= 0 && k == first_en + 3) begin
        chk("rst_abort", {cal_en, busy, done, tri_en}, 4'b0);
        fin = 1;
      end else begin
        if (trig_feed && first_en >= 0 && k == first_en + 3) chk("trig_in_feed_busy", {busy, cal_en}, 2'b11);
        if (tri_en) begin
          tri_n++;
          tri_c = k;
          tri_num = num_cnt;
        end
        if (cal_en && !pe) begin
          if (first_en < 0) first_en = k;
          cur = {cnt, decode_out, counter_out};
          got_q.push_back(cur);
          hold_on = 1;
        end else if (hold_on && {cnt, decode_out, counter_out} !== cur) unstable++;
        if (!cal_en && pe && int'(cnt) == hold) fall_c = k;
        if (fall_c >= 0 && k == fall_c + 15) chk("timeout_not_early", timeout_err, 1'b0);
        if (fall_c >= 0 && k == fall_c + 16) chk("timeout_set", timeout_err, 1'b1);
        if (out_valid || done) hold_on = 0;
        pe = cal_en;
        if (done) begin
          done_n++;
          done_c = k;
          chk("done_not_busy", busy, 1'b0);
        end
        if (done_c >= 0 && k == done_c + 3) fin = 1;
        if (k > 3000) begin
          chk("shot_bound", k, 3000);
          fin = 1;
        end
      end
    end
    rst = 1'b0;
    trig = 1'b0;
    hit_valid = 1'b0;
    hold_idx = 0;
    if (rst_feed) return;
    chk("tri_en_count", tri_n, s >= 0 ? 1 : 0);
    if (s >= 0) begin
      chk("num_cnt_at_load", tri_num, nstop);
      chk("tri_en_cycle", tri_c, s + win + 2);
      chk("first_cal_en_cycle", first_en, s + win + 3);
    end else chk("nostart_done_cycle", done_c, ws_end + 1);
    chk("feed_count", got_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got_q.size()) chk($sformatf("feed%0d", i), got_q[i], exp_q[i]);
    chk("overflow", overflow, ov_exp);
    chk("timeout_err", timeout_err, to_exp);
    chk("done_count", done_n, 1);
    chk("feed_stable", unstable, 0);
    chk("num_cnt_hold", num_cnt, nstop);
  endtask

  initial begin
    int tq[$];
    int w, st0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ctrl", {busy, done, cal_en, tri_en, overflow, timeout_err}, 6'b0);
    chk("reset_cnt", {cnt, num_cnt}, 6'b0);
    chk("reset_data", {decode_out, counter_out}, 30'b0);
    trig = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_beats_trig", busy, 1'b0);
    rst = 1'b0;
    idle(3);
    tq.delete(); tq.push_back(3);
    for (int i = 1; i <= 3; i++) tq.push_back(3 + 10 * i);
    run_shot(50, tq, 0, 0, 0);
    idle(6);
    tq.delete(); tq.push_back(2);
    for (int i = 1; i <= 8; i++) tq.push_back(2 + 5 * i);
    run_shot(60, tq, 0, 0, 0);
    idle(6);
    tq.delete();
    run_shot(20, tq, 0, 0, 0);
    idle(6);
    tq.delete(); tq.push_back(1); tq.push_back(5); tq.push_back(9);
    run_shot(30, tq, 2, 0, 0);
    idle(6);
    tq.delete(); tq.push_back(4); tq.push_back(15); tq.push_back(16);
    run_shot(10, tq, 0, 1, 0);
    idle(6);
    tq.delete(); tq.push_back(2); tq.push_back(4); tq.push_back(6);
    run_shot(8, tq, 0, 0, 1);
    idle(6);
    tq.delete(); tq.push_back(2); tq.push_back(5); tq.push_back(9); tq.push_back(14);
    run_shot(12, tq, 0, 0, 0);
    idle(6);
    for (int r = 0; r < 6; r++) begin
      w = int'($urandom_range(0, 30));
      st0 = int'($urandom_range(1, w + 3));
      tq.delete();
      tq.push_back(st0);
      for (int t = st0 + 1; t <= st0 + w + 4; t++) if ($urandom_range(0, 2) == 0) tq.push_back(t);
      run_shot(w, tq, $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 3)) : 0, 0, 0);
      idle(6);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tof_seq_ctrl.md
Name: tof_seq_ctrl

Overview:
Per-shot sequencer for the TOF calculation datapath. On a laser trigger it opens a stop-hit acceptance window and buffers the start hit plus up to MAX_STOPS stop hits. Each hit is a 16-bit thermometer fine code with a 14-bit coarse count. After the window closes it loads the hit count into the datapath, then replays the hits one at a time. For each hit it drives the calculator's enable, hit index and data, and waits for its result strobe. It sits between the TDC capture front-end and the TOF calculator.

Parameters:
MAX_STOPS, 5, max stop hits per shot (hit index 2..MAX_STOPS+1, must fit 3 bits)
FIFO_DEPTH, 8, hit buffer entries (>= MAX_STOPS+1, power of 2)
RES_TIMEOUT, 16, cycles to wait for calculator out_valid before forcing advance

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
trig  in  1  laser trigger pulse, one cycle
win_len  in  16  stop window length in cycles, sampled at trig
hit_valid  in  1  TDC hit strobe, one cycle per hit
hit_code  in  16  thermometer fine code of the hit
hit_coarse  in  14  coarse counter value of the hit
decode_out  out  16  fine code presented to the calculator
counter_out  out  14  coarse count presented to the calculator
cal_en  out  1  calculator pipeline enable
cnt  out  3  index of the hit being processed (1=start, 2..6=stop)
num_cnt  out  3  number of stop hits captured this shot
tri_en  out  1  one-cycle load of num_cnt into the calculator
cal_stop  in  1  calculator end-of-decode flag
out_valid  in  1  calculator result strobe
busy  out  1  shot in progress
done  out  1  one-cycle pulse when the shot completes
overflow  out  1  sticky: a stop hit was dropped (cleared on next trig)
timeout_err  out  1  sticky: result wait timed out (cleared on next trig)

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE; FIFO is emptied.
  - All outputs are 0, except cnt=0 and num_cnt=0.
  - Reset mid-shot aborts the shot; no done pulse is issued.
- States: IDLE, WAIT_START, WINDOW, LOAD, FEED, WAIT_RES, DONE.
- IDLE:
  - trig moves to WAIT_START.
  - win_len is latched, overflow and timeout_err are cleared, and the stop count is cleared.
  - busy=1 from the next cycle.
- WAIT_START:
  - The first hit_valid is pushed as the start entry (index 1).
  - The window down-counter is loaded with win_len and the state moves to WINDOW.
  - No start hit within win_len cycles of trig goes to DONE with num_cnt=0; nothing is fed.
- WINDOW:
  - The counter decrements each cycle; each hit_valid pushes an entry and increments the stop count.
  - Hits after MAX_STOPS are dropped and set overflow.
  - The counter reaching 0 moves to LOAD.
  - A hit arriving on the same cycle the counter hits 0 is still accepted.
  - win_len=0 closes the window on the cycle after the start hit.
- LOAD:
  - num_cnt is driven with the stop count.
  - tri_en=1 for exactly one cycle, then FEED.
  - num_cnt holds its value until the next trig.
- FEED:
  - The FIFO head drives decode_out and counter_out; cnt = entry index.
  - cal_en=1 from FEED entry until the cycle after cal_stop is seen high, giving 5 cycles nominal.
  - decode_out, counter_out and cnt are stable throughout cal_en and until out_valid.
  - The entry is popped when cal_en drops; the state then moves to WAIT_RES.
- WAIT_RES:
  - out_valid moves to FEED if the FIFO is not empty, otherwise to DONE.
  - No out_valid within RES_TIMEOUT cycles sets timeout_err and advances the same way.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Simultaneous events:
  - trig while busy is ignored.
  - hit_valid outside WAIT_START/WINDOW is ignored and does not set overflow.
  - trig and rst on the same cycle: rst wins.
- Widths: the stop count saturates at MAX_STOPS. The FIFO entry is 33 bits: index 3, code 16, coarse 14.
- Latency: trig to the first cal_en rise = wait for start hit + win_len + 3 cycles.

Decomposition:
- Package tof_pkg holds:
  - the state enum;
  - the hit entry struct (idx, code, coarse);
  - constants IDX_START=1 and IDX_W=3.
- One sub-module, tof_hit_fifo: synchronous FIFO (push, pop, full, empty, head). It has no look-ahead; the head is valid whenever not empty.

Test Plan:
- Single shot, start hit plus 3 stops at 10/20/30 cycles after start, win_len=50:
  - tri_en is pulsed once with num_cnt=3.
  - Four feeds occur, with cnt=1,2,3,4 and matching codes and coarse values.
  - done is pulsed once.
- 8 stop hits inside the window:
  - only 5 are fed;
  - num_cnt=5 and overflow=1;
  - overflow clears on the next trig.
- No start hit, win_len=20: done is pulsed 21 cycles after trig; cal_en and tri_en never assert.
- Calculator model withholds out_valid for the 2nd hit:
  - timeout_err is set after 16 cycles;
  - the 3rd hit is still fed.
- A hit on the exact cycle the window expires is accepted; trig during FEED is ignored and busy stays 1.
- rst asserted mid-FEED:
  - the next cycle shows cal_en=0, busy=0 and the FIFO empty;
  - a new trig runs a clean shot.
